// File: rtl/fifo_pkg.sv
// Shared constants, width helpers and the status bundle type for the
// parametrised synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    // A depth of 1 would give a zero-width pointer, so clamp to one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for the FIFO: one write port and one
// registered read port whose output register clears on reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_en,
    input  logic [ptr_width(DEPTH)-1:0] write_addr,
    input  logic [DATA_W-1:0]           write_data,
    input  logic                        read_en,
    input  logic [ptr_width(DEPTH)-1:0] read_addr,
    output logic [DATA_W-1:0]           read_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read-before-write on the same address returns the old word, which is
    // exactly what a simultaneous read/write on a full FIFO needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= mem[read_addr];
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [DATA_W-1:0]             data_in,
    output logic [DATA_W-1:0]             data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          err_clr
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    fifo_status_t  status;
    logic          rd_accept;
    logic          wr_accept;

    always_comb begin
        status.full         = (count_q == CW'(DEPTH));
        status.empty        = (count_q == '0);
        status.almost_full  = (int'(count_q) >= AF_THRESH);
        status.almost_empty = (int'(count_q) <= AE_THRESH);
    end

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_accept = read_en && !status.empty;
    assign wr_accept = write_en && (!status.full || rd_accept);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (wr_accept && !rd_accept) begin
            count_q <= count_q + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_q <= count_q - CW'(1);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .write_en   (wr_accept),
        .write_addr (wr_ptr),
        .write_data (data_in),
        .read_en    (rd_accept),
        .read_addr  (rd_ptr),
        .read_data  (data_out)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;
    logic overflow_event;
    logic underflow_event;

    assign overflow_event  = write_en && !wr_accept;
    assign underflow_event = read_en && status.empty;

    // A fresh error on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_event) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (underflow_event) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed, table-driven bench for fifo_sync_param at default parameters,
// plus hand-written asynchronous reset sequences.
module tb_fifo_sync_param;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int n_applied;
    int n_miscompares;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic       clr;
        logic [4:0] exp_count;
        logic [7:0] exp_dout;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_param dut (
        .clk          (clk),
        .rst          (rst),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add_vec(input logic we, input logic re, input logic [7:0] din,
                           input logic clr, input int cnt, input logic [7:0] dout,
                           input logic ovf, input logic unf);
        vec_t v;
        v.we        = we;
        v.re        = re;
        v.din       = din;
        v.clr       = clr;
        v.exp_count = 5'(cnt);
        v.exp_dout  = dout;
        v.exp_ovf   = ovf;
        v.exp_unf   = unf;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input logic we, input logic re, input logic [7:0] din,
                                  input logic clr);
        write_en = we;
        read_en  = re;
        data_in  = din;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Flags are judged from the expected occupancy with the default thresholds 14 and 2.
    task automatic check_state(input string tag, input int cnt, input logic [7:0] dout,
                               input logic ovf, input logic unf);
        check_output({tag, " count"}, 32'(count), 32'(cnt));
        check_output({tag, " data_out"}, 32'(data_out), 32'(dout));
        check_output({tag, " full"}, 32'(full), 32'(cnt == 16));
        check_output({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        check_output({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 14));
        check_output({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
        check_output({tag, " overflow"}, 32'(overflow), 32'(ovf));
        check_output({tag, " underflow"}, 32'(underflow), 32'(unf));
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = 8'h00;
        err_clr  = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) add_vec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // Fill 0x01..0x10, then a dropped 17th write
        for (int i = 1; i <= 16; i++) add_vec(1, 0, 8'(i), 0, i, 8'h00, 0, 0);
        add_vec(1, 0, 8'hFF, 0, 16, 8'h00, ERR_EN, 0);
        // Drain in order, then an extra read on empty
        for (int i = 1; i <= 16; i++) add_vec(0, 1, 8'h00, 0, 16 - i, 8'(i), ERR_EN, 0);
        add_vec(0, 1, 8'h00, 0, 0, 8'h10, ERR_EN, ERR_EN);
        // err_clr, and a new underflow on the same edge as err_clr
        add_vec(0, 0, 8'h00, 1, 0, 8'h10, 0, 0);
        add_vec(0, 1, 8'h00, 1, 0, 8'h10, 0, ERR_EN);
        add_vec(0, 0, 8'h00, 1, 0, 8'h10, 0, 0);
        // Wrap-around
        for (int i = 0; i < 10; i++) add_vec(1, 0, 8'(8'h30 + i), 0, i + 1, 8'h10, 0, 0);
        for (int i = 0; i < 10; i++) add_vec(0, 1, 8'h00, 0, 9 - i, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 16; i++) add_vec(1, 0, 8'(8'hA0 + i), 0, i + 1, 8'h39, 0, 0);
        // Simultaneous read/write while full
        add_vec(1, 1, 8'h55, 0, 16, 8'hA0, 0, 0);
        for (int i = 1; i <= 15; i++) add_vec(0, 1, 8'h00, 0, 16 - i, 8'(8'hA0 + i), 0, 0);
        add_vec(0, 1, 8'h00, 0, 0, 8'h55, 0, 0);
        // Simultaneous read/write while empty
        add_vec(1, 1, 8'h77, 0, 1, 8'h55, 0, ERR_EN);
        add_vec(0, 0, 8'h00, 1, 1, 8'h55, 0, 0);
        add_vec(0, 1, 8'h00, 0, 0, 8'h77, 0, 0);

        #1;
        check_state("reset_held", 0, 8'h00, 0, 0);
        #5;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].we, vecs[i].re, vecs[i].din, vecs[i].clr);
            check_state($sformatf("vec%0d", i), int'(vecs[i].exp_count), vecs[i].exp_dout,
                        vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Underflow, then five writes, then async reset in the middle of a write
        apply_stimulus(0, 1, 8'h00, 0);
        check_state("pre_rst_unf", 0, 8'h77, 0, ERR_EN);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 8'(8'hC0 + i), 0);
        check_state("pre_rst_fill", 5, 8'h77, 0, ERR_EN);

        write_en = 1'b1;
        data_in  = 8'hEE;
        #2;
        rst = 1'b0;
        #1;
        check_state("async_rst", 0, 8'h00, 0, 0);

        @(posedge clk);
        #1;
        check_state("rst_held_write", 0, 8'h00, 0, 0);
        write_en = 1'b0;
        rst      = 1'b1;

        apply_stimulus(0, 0, 8'h00, 0);
        check_state("post_rst_idle", 0, 8'h00, 0, 0);
        apply_stimulus(1, 0, 8'h3C, 0);
        check_state("post_rst_write", 1, 8'h00, 0, 0);
        apply_stimulus(0, 1, 8'h00, 0);
        check_state("post_rst_read", 0, 8'h3C, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
